// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;
    localparam int WAIT_CNT_W  = 8;

    localparam logic [WAIT_CNT_W-1:0] MEM_TIMEOUT = 8'd255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_e;

    function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] value);
        sat_inc_stall = (value == {STALL_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage source that depends on a load still in EX.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  load_use
);

    logic rd_nonzero;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign rd_nonzero = (ex_rd != '0);
    assign rs1_match  = (ex_rd == id_rs1);
    assign rs2_match  = (ex_rd == id_rs2);
    assign load_use   = mem_read && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles, branch flushes and data-memory wait states.
module hazard_stall_ctrl
    import hazard_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  IDEX_Rd_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rs1_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rs2_i,
    input  logic                   branch_taken_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ack_i,
    output logic                   PCWrite_o,
    output logic                   IFID_Write_o,
    output logic                   NoOp_o,
    output logic                   IFID_Flush_o,
    output logic                   Pipe_Stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   err_o
);

    hazard_state_e         state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  lu;
    logic                  ms;

    hazard_detect u_detect (
        .mem_read (IDEX_MemRead_i),
        .ex_rd    (IDEX_Rd_i),
        .id_rs1   (IFID_Rs1_i),
        .id_rs2   (IFID_Rs2_i),
        .load_use (lu)
    );

    // A request acked in its own cycle never stalls; once waiting, only the ack matters.
    assign ms = ((state == MEM_WAIT) || dmem_req_i) && !dmem_ack_i;

    always_comb begin
        PCWrite_o    = 1'b1;
        IFID_Write_o = 1'b1;
        NoOp_o       = 1'b0;
        IFID_Flush_o = 1'b0;
        Pipe_Stall_o = 1'b0;
        if (ms) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            Pipe_Stall_o = 1'b1;
        end else if (lu) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            NoOp_o       = 1'b1;
        end else begin
            IFID_Flush_o = branch_taken_i;
        end
    end

    // Wait counter saturates at the timeout so the sticky error cannot be missed by a wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            if (ms || lu) begin
                stall_cnt_o <= sat_inc_stall(stall_cnt_o);
            end
            case (state)
                RUN: begin
                    if (dmem_req_i && !dmem_ack_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        state <= RUN;
                    end else begin
                        if (wait_cnt != MEM_TIMEOUT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt == (MEM_TIMEOUT - 1'b1)) begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: rule-level model plus hand-computed checkpoints.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        branch = 1'b0;
    logic        req = 1'b0;
    logic        ack = 1'b0;
    logic        pc_write;
    logic        ifid_write;
    logic        noop;
    logic        flush;
    logic        pipe_stall;
    logic [15:0] stall_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    bit m_wait   = 1'b0;
    int m_wcount = 0;
    int m_stall  = 0;
    bit m_err    = 1'b0;

    typedef struct {
        bit       mr;
        bit [4:0] rd;
        bit [4:0] r1;
        bit [4:0] r2;
        bit       br;
        bit       rq;
        bit       ak;
    } vec_t;

    hazard_stall_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IDEX_MemRead_i (mem_read),
        .IDEX_Rd_i      (ex_rd),
        .IFID_Rs1_i     (rs1),
        .IFID_Rs2_i     (rs2),
        .branch_taken_i (branch),
        .dmem_req_i     (req),
        .dmem_ack_i     (ack),
        .PCWrite_o      (pc_write),
        .IFID_Write_o   (ifid_write),
        .NoOp_o         (noop),
        .IFID_Flush_o   (flush),
        .Pipe_Stall_o   (pipe_stall),
        .stall_cnt_o    (stall_cnt),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    function automatic bit model_lu();
        return mem_read && (ex_rd != 0) && ((ex_rd == rs1) || (ex_rd == rs2));
    endfunction

    function automatic bit model_ms();
        return (m_wait || req) && !ack;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit mr, input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2,
                                 input bit br, input bit rq, input bit ak);
        @(posedge clk);
        #1;
        mem_read = mr;
        ex_rd    = rd;
        rs1      = r1;
        rs2      = r2;
        branch   = br;
        req      = rq;
        ack      = ak;
        @(negedge clk);
    endtask

    // Model state advances on the clock; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait   = 1'b0;
            m_wcount = 0;
            m_stall  = 0;
            m_err    = 1'b0;
        end else begin
            if (model_ms() || model_lu()) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (m_wait) begin
                if (ack) m_wait = 1'b0;
                else begin
                    m_wcount++;
                    if (m_wcount >= 255) m_err = 1'b1;
                end
            end else if (req && !ack) begin
                m_wait   = 1'b1;
                m_wcount = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit lu_e;
        bit ms_e;
        lu_e = model_lu();
        ms_e = model_ms();
        checkOutput("pipe_stall", {31'b0, pipe_stall}, {31'b0, ms_e});
        checkOutput("pc_write",   {31'b0, pc_write},   {31'b0, !ms_e && !lu_e});
        checkOutput("ifid_write", {31'b0, ifid_write}, {31'b0, !ms_e && !lu_e});
        checkOutput("noop",       {31'b0, noop},       {31'b0, !ms_e && lu_e});
        checkOutput("flush",      {31'b0, flush},      {31'b0, !ms_e && !lu_e && branch});
        checkOutput("stall_cnt",  {16'b0, stall_cnt},  m_stall);
        checkOutput("err",        {31'b0, err},        {31'b0, m_err});
    end

    initial begin
        vec_t vecs[8];
        vecs = '{'{1, 31, 31, 31, 1, 0, 0}, '{1, 31, 30, 29, 1, 0, 0}, '{0, 3, 3, 3, 1, 0, 0},
                 '{1, 2, 1, 2, 0, 1, 0},    '{1, 2, 1, 2, 1, 0, 0},    '{0, 0, 0, 0, 1, 0, 1},
                 '{0, 0, 0, 0, 0, 1, 1},    '{1, 6, 6, 0, 1, 0, 0}};

        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_pc_write", {31'b0, pc_write}, 1);
        checkOutput("reset_ifid_write", {31'b0, ifid_write}, 1);
        checkOutput("reset_noop", {31'b0, noop}, 0);
        checkOutput("reset_flush", {31'b0, flush}, 0);
        checkOutput("reset_pipe_stall", {31'b0, pipe_stall}, 0);
        checkOutput("reset_stall_cnt", {16'b0, stall_cnt}, 0);
        checkOutput("reset_err", {31'b0, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load x5 in EX feeding Rs1 in ID: one bubble.
        applyStimulus(1, 5, 5, 0, 0, 0, 0);
        checkOutput("lu_pc_write", {31'b0, pc_write}, 0);
        checkOutput("lu_ifid_write", {31'b0, ifid_write}, 0);
        checkOutput("lu_noop", {31'b0, noop}, 1);
        checkOutput("lu_stall_cnt_before", {16'b0, stall_cnt}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_stall_cnt_after", {16'b0, stall_cnt}, 1);
        checkOutput("lu_released", {31'b0, pc_write}, 1);

        // Load to x0 is never a hazard.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_pc_write", {31'b0, pc_write}, 1);
        checkOutput("x0_noop", {31'b0, noop}, 0);

        // Branch suppressed under load-use, then flushes once operands are ready.
        applyStimulus(1, 7, 3, 7, 1, 0, 0);
        checkOutput("br_lu_flush", {31'b0, flush}, 0);
        checkOutput("br_lu_noop", {31'b0, noop}, 1);
        applyStimulus(0, 7, 3, 7, 1, 0, 0);
        checkOutput("br_flush", {31'b0, flush}, 1);
        checkOutput("br_noop", {31'b0, noop}, 0);
        checkOutput("br_stall_cnt", {16'b0, stall_cnt}, 2);

        // Memory access acked after three cycles; load-use during the wait is ignored.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("mem_c0_stall", {31'b0, pipe_stall}, 1);
        checkOutput("mem_c0_pc_write", {31'b0, pc_write}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("mem_c1_stall", {31'b0, pipe_stall}, 1);
        applyStimulus(1, 4, 4, 0, 1, 0, 0);
        checkOutput("mem_c2_stall", {31'b0, pipe_stall}, 1);
        checkOutput("mem_c2_noop", {31'b0, noop}, 0);
        checkOutput("mem_c2_flush", {31'b0, flush}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("mem_ack_stall", {31'b0, pipe_stall}, 0);
        checkOutput("mem_ack_pc_write", {31'b0, pc_write}, 1);
        checkOutput("mem_stall_cnt", {16'b0, stall_cnt}, 5);

        // Request acked in the same cycle: no stall at all.
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("fast_ack_stall", {31'b0, pipe_stall}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fast_ack_after", {31'b0, pipe_stall}, 0);
        checkOutput("fast_ack_stall_cnt", {16'b0, stall_cnt}, 5);

        // Memory never acks: error after 255 complete wait cycles, then reset mid-wait.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (254) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_err_pending", {31'b0, err}, 0);
        checkOutput("timeout_still_stalled", {31'b0, pipe_stall}, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_err_set", {31'b0, err}, 1);
        checkOutput("timeout_stall_cnt", {16'b0, stall_cnt}, 261);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_stall", {31'b0, pipe_stall}, 0);
        checkOutput("rst_mid_err", {31'b0, err}, 0);
        checkOutput("rst_mid_stall_cnt", {16'b0, stall_cnt}, 0);
        checkOutput("rst_mid_pc_write", {31'b0, pc_write}, 1);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1, 9, 0, 9, 0, 0, 0);
        checkOutput("post_rst_noop", {31'b0, noop}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_stall_cnt", {16'b0, stall_cnt}, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].mr, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].br, vecs[i].rq, vecs[i].ak);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
